// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int unsigned MEM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase counter: counts up to WAIT_CYCLES and flags the last cycle of a phase.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_last
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_last = (r_cnt == CNT_W'(WAIT_CYCLES));

    // Saturating count, cleared synchronously at the end of each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!o_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Turns one 32-bit pipeline memory request into two 16-bit asynchronous SRAM
// accesses, stalling the pipeline via ready while the access is in flight.
module sram_controller
    import mem_pkg::*;
#(
    parameter int unsigned DATA_LEN      = 32,
    parameter int unsigned ADDRESS_LEN   = 32,
    parameter int unsigned SRAM_ADDR_LEN = 18,
    parameter int unsigned SRAM_DATA_LEN = 16,
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter int unsigned BASE_ADDR     = MEM_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MEM_R_EN,
    input  logic                     MEM_W_EN,
    input  logic [ADDRESS_LEN-1:0]   ALU_Res,
    input  logic [DATA_LEN-1:0]      Val_Rm,
    output logic [DATA_LEN-1:0]      MEM_OUT,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic [SRAM_DATA_LEN-1:0] SRAM_DQ_OUT,
    output logic                     SRAM_DQ_OE,
    input  logic [SRAM_DATA_LEN-1:0] SRAM_DQ_IN,
    output logic                     SRAM_WE_N
);

    mem_state_e                     r_state;
    mem_state_e                     w_next;
    logic [SRAM_ADDR_LEN-2:0]       r_word;
    logic [DATA_LEN-1:0]            r_wdata;
    logic                           r_is_write;
    logic [SRAM_DATA_LEN-1:0]       r_lo;
    logic [DATA_LEN-1:0]            r_out;
    logic                           w_req;
    logic                           w_last;
    logic                           w_clr;
    logic                           w_in_phase;

    assign w_req      = MEM_R_EN | MEM_W_EN;
    assign w_in_phase = (r_state == LOW) || (r_state == HIGH);
    assign w_clr      = !w_in_phase || w_last;
    assign MEM_OUT    = r_out;
    assign ready      = ((r_state == IDLE) && !w_req) || (r_state == DONE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_last (w_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) w_next = LOW;
                else       w_next = IDLE;
            end
            LOW: begin
                if (w_last) w_next = HIGH;
                else        w_next = LOW;
            end
            HIGH: begin
                if (w_last) w_next = DONE;
                else        w_next = HIGH;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pad decode; pads are quiet outside LOW/HIGH so reset silences them at once.
    always_comb begin
        SRAM_ADDR   = '0;
        SRAM_DQ_OUT = '0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        case (r_state)
            LOW: begin
                SRAM_ADDR = {r_word, 1'b0};
                if (r_is_write) begin
                    SRAM_DQ_OUT = r_wdata[SRAM_DATA_LEN-1:0];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end else begin
                    SRAM_DQ_OE  = 1'b0;
                    SRAM_WE_N   = 1'b1;
                end
            end
            HIGH: begin
                SRAM_ADDR = {r_word, 1'b1};
                if (r_is_write) begin
                    SRAM_DQ_OUT = r_wdata[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end else begin
                    SRAM_DQ_OE  = 1'b0;
                    SRAM_WE_N   = 1'b1;
                end
            end
            default: begin
                SRAM_ADDR   = '0;
                SRAM_DQ_OUT = '0;
                SRAM_DQ_OE  = 1'b0;
                SRAM_WE_N   = 1'b1;
            end
        endcase
    end

    // Request capture; a simultaneous read+write is treated as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if ((r_state == IDLE) && w_req) begin
            r_word     <= (SRAM_ADDR_LEN-1)'((ALU_Res - ADDRESS_LEN'(BASE_ADDR)) >> 2);
            r_wdata    <= Val_Rm;
            r_is_write <= MEM_W_EN;
        end else begin
            r_word     <= r_word;
            r_wdata    <= r_wdata;
            r_is_write <= r_is_write;
        end
    end

    // Read data capture on the last cycle of each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lo  <= '0;
            r_out <= '0;
        end else if (!r_is_write && w_last && (r_state == LOW)) begin
            r_lo  <= SRAM_DQ_IN;
            r_out <= r_out;
        end else if (!r_is_write && w_last && (r_state == HIGH)) begin
            r_lo  <= r_lo;
            r_out <= {SRAM_DQ_IN, r_lo};
        end else begin
            r_lo  <= r_lo;
            r_out <= r_out;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller with an SRAM pad model
// and a transaction-level reference memory.
module tb_sram_controller;

    localparam int W    = 1;
    localparam int P    = W + 1;
    localparam int L    = 2 * P + 2;
    localparam int AW   = 18;
    localparam int NMEM = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   ALU_Res;
    logic [31:0]   Val_Rm;
    logic [31:0]   MEM_OUT;
    logic          ready;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_OUT;
    logic          SRAM_DQ_OE;
    logic [15:0]   SRAM_DQ_IN;
    logic          SRAM_WE_N;

    logic [15:0]   sram    [0:NMEM-1];
    logic [15:0]   ref_mem [0:NMEM-1];

    int n_checks = 0;
    int n_err    = 0;

    logic [AW-1:0] cap_addr [0:L-1];
    logic [15:0]   cap_dq   [0:L-1];
    logic          cap_we   [0:L-1];
    logic          cap_rdy  [0:L-1];
    logic [31:0]   cap_out  [0:L-1];

    sram_controller #(
        .DATA_LEN      (32),
        .ADDRESS_LEN   (32),
        .SRAM_ADDR_LEN (AW),
        .SRAM_DATA_LEN (16),
        .WAIT_CYCLES   (W),
        .BASE_ADDR     (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_Res     (ALU_Res),
        .Val_Rm      (Val_Rm),
        .MEM_OUT     (MEM_OUT),
        .ready       (ready),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_WE_N   (SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM pad model.
    assign SRAM_DQ_IN = sram[SRAM_ADDR];
    always @(posedge clk) begin
        if (rst_n && !SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ_OUT;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: k = cycle within current access (-1 when idle).
    int          m_k = -1;
    logic        m_we;
    logic [16:0] m_word;
    logic [31:0] m_data;
    logic [31:0] m_out = 32'd0;

    always @(negedge clk) begin
        logic          req;
        logic          hi;
        logic [AW-1:0] ha;
        req = MEM_R_EN | MEM_W_EN;
        if (!rst_n) begin
            chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
            chk("rst_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
            chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
            chk("rst_out", MEM_OUT, 32'd0);
            chk("rst_ready", {31'd0, ready}, {31'd0, !req});
            m_k   = -1;
            m_out = 32'd0;
        end else begin
            chk("mem_out", MEM_OUT, m_out);
            if (m_k < 0) begin
                chk("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
                chk("idle_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
                chk("idle_addr", {14'd0, SRAM_ADDR}, 32'd0);
                chk("idle_dq", {16'd0, SRAM_DQ_OUT}, 32'd0);
                chk("idle_ready", {31'd0, ready}, {31'd0, !req});
                if (req) begin
                    m_we   = MEM_W_EN;
                    m_word = 17'((ALU_Res - 32'd1024) >> 2);
                    m_data = Val_Rm;
                    m_k    = 1;
                end
            end else if (m_k <= 2 * P) begin
                hi = (m_k > P);
                ha = {m_word, hi};
                chk("ph_addr", {14'd0, SRAM_ADDR}, {14'd0, ha});
                chk("ph_ready", {31'd0, ready}, 32'd0);
                chk("ph_we_n", {31'd0, SRAM_WE_N}, {31'd0, !m_we});
                chk("ph_oe", {31'd0, SRAM_DQ_OE}, {31'd0, m_we});
                if (m_we)
                    chk("ph_dq", {16'd0, SRAM_DQ_OUT}, {16'd0, (hi ? m_data[31:16] : m_data[15:0])});
                if (m_k == P && m_we) ref_mem[ha] = m_data[15:0];
                if (m_k == 2 * P) begin
                    if (m_we) ref_mem[ha] = m_data[31:16];
                    else      m_out = {ref_mem[ha], ref_mem[{m_word, 1'b0}]};
                end
                m_k++;
            end else begin
                chk("done_we_n", {31'd0, SRAM_WE_N}, 32'd1);
                chk("done_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
                chk("done_addr", {14'd0, SRAM_ADDR}, 32'd0);
                chk("done_ready", {31'd0, ready}, 32'd1);
                m_k = -1;
            end
        end
    end

    task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        MEM_W_EN = we;
        MEM_R_EN = re;
        ALU_Res  = a;
        Val_Rm   = d;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            cap_addr[k] = SRAM_ADDR;
            cap_dq[k]   = SRAM_DQ_OUT;
            cap_we[k]   = SRAM_WE_N;
            cap_rdy[k]  = ready;
            cap_out[k]  = MEM_OUT;
            if (k < L - 1) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            MEM_W_EN = 1'b0;
            MEM_R_EN = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int          sel;
        rst_n    = 1'b0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        ALU_Res  = 32'd0;
        Val_Rm   = 32'd0;
        for (int i = 0; i < NMEM; i++) begin
            d          = $urandom;
            sram[i]    = d[15:0];
            ref_mem[i] = d[15:0];
        end
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("reset_mem_out", MEM_OUT, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        chk("wr_addr_c1", {14'd0, cap_addr[1]}, 32'd2);
        chk("wr_addr_c2", {14'd0, cap_addr[2]}, 32'd2);
        chk("wr_dq_c1", {16'd0, cap_dq[1]}, 32'h0000BEEF);
        chk("wr_we_c1", {31'd0, cap_we[1]}, 32'd0);
        chk("wr_addr_c3", {14'd0, cap_addr[3]}, 32'd3);
        chk("wr_dq_c4", {16'd0, cap_dq[4]}, 32'h0000DEAD);
        chk("wr_ready_c5", {31'd0, cap_rdy[5]}, 32'd1);
        idle(2);
        chk("wr_sram2", {16'd0, sram[2]}, 32'h0000BEEF);
        chk("wr_sram3", {16'd0, sram[3]}, 32'h0000DEAD);

        access(1'b0, 1'b1, 32'd1028, 32'd0);
        for (int k = 0; k < L - 1; k++) chk("rd_ready_low", {31'd0, cap_rdy[k]}, 32'd0);
        chk("rd_ready_c5", {31'd0, cap_rdy[5]}, 32'd1);
        chk("rd_out_c5", cap_out[5], 32'hDEADBEEF);
        idle(1);

        access(1'b1, 1'b0, 32'd1024, 32'h12345678);
        access(1'b0, 1'b1, 32'd1024, 32'd0);
        chk("b2b_addr_c1", {14'd0, cap_addr[1]}, 32'd0);
        chk("b2b_out_c11", cap_out[5], 32'h12345678);
        idle(1);

        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
        chk("both_out", cap_out[5], 32'h12345678);
        idle(1);
        chk("both_sram4", {16'd0, sram[4]}, 32'h0000F00D);
        chk("both_sram5", {16'd0, sram[5]}, 32'h0000CAFE);

        access(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131072, 32'hA5A55A5A);
        chk("wrap_lo", {14'd0, cap_addr[1]}, 32'd0);
        chk("wrap_hi", {14'd0, cap_addr[3]}, 32'd1);
        idle(1);
        chk("wrap_sram0", {16'd0, sram[0]}, 32'h00005A5A);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 15));
            d = $urandom;
            case (sel)
                0:       access(1'b1, 1'b0, a, d);
                1:       access(1'b1, 1'b1, a, d);
                default: access(1'b0, 1'b1, a, d);
            endcase
            idle($urandom_range(0, 2));
        end
        idle(1);

        d = 32'h0BADF00D;
        @(posedge clk);
        #1;
        MEM_W_EN = 1'b1;
        ALU_Res  = 32'd1040;
        Val_Rm   = d;
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("mid_rst_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_out", MEM_OUT, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        #1;
        chk("post_rst_ready", {31'd0, ready}, 32'd1);
        chk("post_rst_lo", {16'd0, sram[8]}, 32'h0000F00D);
        chk("post_rst_hi", {16'd0, sram[9]}, {16'd0, ref_mem[9]});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
